// File: rtl/fetch_pkg.sv
// Shared types and constants for the IF/ID fetch queue.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage: one synchronous write port, one combinational read port, no reset.
module fetch_queue_mem
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         we_i,
  input  logic [AW-1:0] waddr_i,
  input  fetch_entry_t wdata_i,
  input  logic [AW-1:0] raddr_i,
  output fetch_entry_t rdata_o
);

  fetch_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_fetch_queue.sv
// In-order IF->ID decoupling FIFO with valid/ready to ID, hold to IF and branch flush.
module if_id_fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  if_pc,
  input  logic [XLEN-1:0]  if_pc_plus4,
  input  logic [XLEN-1:0]  if_instr,
  input  logic             if_valid,
  output logic             if_hold,
  input  logic             flush,
  input  logic             id_ready,
  output logic             id_valid,
  output logic [XLEN-1:0]  id_pc,
  output logic [XLEN-1:0]  id_pc_plus4,
  output logic [XLEN-1:0]  id_instr,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full, empty, push, pop;
  fetch_entry_t     wr_entry, head;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign if_hold  = full & ~flush;
  assign id_valid = ~empty;
  // A pop never frees room for a same-cycle push: IF is already held.
  assign push     = if_valid & ~full & ~flush;
  assign pop      = id_valid & id_ready & ~flush;

  assign wr_entry = '{pc: if_pc, pc_plus4: if_pc_plus4, instr: if_instr};

  fetch_queue_mem #(.DEPTH(DEPTH), .AW(PTR_W)) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Mask the head when empty so ID never sees stale storage.
  always_comb begin
    id_pc       = '0;
    id_pc_plus4 = '0;
    id_instr    = NOP_INSTR;
    if (!empty) begin
      id_pc       = head.pc;
      id_pc_plus4 = head.pc_plus4;
      id_instr    = head.instr;
    end
  end

  assign count = count_q;

  a_count_bound: assert property (@(posedge clk) disable iff (!rst)
    count_q <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Directed bench for if_id_fetch_queue with hand-computed expectations.
module tb_if_id_fetch_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [31:0]      if_pc = '0, if_pc_plus4 = '0, if_instr = '0;
  logic             if_valid = 1'b0, flush = 1'b0, id_ready = 1'b0;
  logic             if_hold, id_valid;
  logic [31:0]      id_pc, id_pc_plus4, id_instr;
  logic [CNT_W-1:0] count;

  int checks = 0;
  int errors = 0;

  if_id_fetch_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .if_pc(if_pc), .if_pc_plus4(if_pc_plus4), .if_instr(if_instr),
    .if_valid(if_valid), .if_hold(if_hold), .flush(flush),
    .id_ready(id_ready), .id_valid(id_valid),
    .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .id_instr(id_instr),
    .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'hA500_0000 | pc;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
    if_valid    = v;
    if_pc       = pc;
    if_pc_plus4 = pc + 32'd4;
    if_instr    = instr_of(pc);
    id_ready    = rdy;
    flush       = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_hold", 32'(if_hold), 32'd0);
    chk("rst_pc", id_pc, 32'd0);
    chk("rst_pc4", id_pc_plus4, 32'd0);
    chk("rst_instr", id_instr, NOP_INSTR);
    #3 rst = 1'b1;

    // three pushes, no pops
    drive(1, 32'h00, 0, 0); step();
    chk("t1_lat_pc", id_pc, 32'h00);
    drive(1, 32'h04, 0, 0); step();
    drive(1, 32'h08, 0, 0); step();
    drive(0, 32'h0, 0, 0);
    chk("t1_count", 32'(count), 32'd3);
    chk("t1_valid", 32'(id_valid), 32'd1);
    chk("t1_pc", id_pc, 32'h00);
    chk("t1_pc4", id_pc_plus4, 32'h04);
    chk("t1_instr", id_instr, instr_of(32'h00));
    chk("t1_hold", 32'(if_hold), 32'd0);

    // fill, then offer a fifth triple while full
    drive(1, 32'h0C, 0, 0); step();
    chk("t2_full_count", 32'(count), 32'd4);
    chk("t2_full_hold", 32'(if_hold), 32'd1);
    drive(1, 32'h10, 0, 0); step(); step();
    chk("t2_blocked_count", 32'(count), 32'd4);
    flush = 1'b1; #1;
    chk("t2_hold_flush", 32'(if_hold), 32'd0);
    flush = 1'b0; #1;
    chk("t2_hold_back", 32'(if_hold), 32'd1);
    // pop while full, push still offered: only the pop happens
    drive(1, 32'h10, 1, 0); step();
    chk("t2_pop_pc", id_pc, 32'h04);
    chk("t2_pop_count", 32'(count), 32'd3);
    chk("t2_pop_hold", 32'(if_hold), 32'd0);
    // drain and confirm 0x10 never got in
    drive(0, 32'h0, 1, 0);
    chk("t2_drain0", id_pc, 32'h04); step();
    chk("t2_drain1", id_pc, 32'h08); step();
    chk("t2_drain2", id_pc, 32'h0C); step();
    chk("t2_empty_valid", 32'(id_valid), 32'd0);
    chk("t2_empty_pc", id_pc, 32'd0);

    // empty with id_ready held
    step();
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_valid", 32'(id_valid), 32'd0);
    chk("t5_pc", id_pc, 32'd0);

    // steady stream, pointers wrap several times
    for (int k = 0; k < 12; k++) begin
      drive(1, 32'h100 + 32'(4 * k), 1, 0); step();
      chk("t3_count", 32'(count), 32'd1);
      chk("t3_pc", id_pc, 32'h100 + 32'(4 * k));
    end
    chk("t3_instr", id_instr, instr_of(32'h12C));

    // build count=3, then flush with push and pop offered
    drive(1, 32'h130, 0, 0); step();
    drive(1, 32'h134, 0, 0); step();
    chk("t4_pre_count", 32'(count), 32'd3);
    drive(1, 32'h138, 1, 1); step();
    drive(0, 32'h0, 0, 0);
    chk("t4_count", 32'(count), 32'd0);
    chk("t4_valid", 32'(id_valid), 32'd0);
    chk("t4_instr", id_instr, NOP_INSTR);
    chk("t4_pc", id_pc, 32'd0);
    drive(1, 32'h200, 0, 0); step();
    drive(0, 32'h0, 0, 0);
    chk("t4_next_pc", id_pc, 32'h200);
    chk("t4_next_pc4", id_pc_plus4, 32'h204);
    chk("t4_next_count", 32'(count), 32'd1);

    // asynchronous reset mid-cycle with count=2
    drive(1, 32'h204, 0, 0); step();
    drive(0, 32'h0, 0, 0);
    chk("t6_pre_count", 32'(count), 32'd2);
    #2 rst = 1'b0;
    #1;
    chk("t6_async_count", 32'(count), 32'd0);
    chk("t6_async_valid", 32'(id_valid), 32'd0);
    #2 rst = 1'b1;
    drive(1, 32'h40, 0, 0); step();
    drive(0, 32'h0, 0, 0);
    chk("t6_post_pc", id_pc, 32'h40);
    chk("t6_post_instr", id_instr, instr_of(32'h40));
    chk("t6_post_count", 32'(count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
